fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and full-flag controller for the asynchronous FIFO. Accepts write requests in the `w_clk` domain and keeps the binary write address driven into the dual-port FIFO memory. Publishes the Gray-coded write pointer to the read domain, synchronizes the read domain's Gray pointer back, and produces the registered `w_full` flag and an occupancy estimate. Sits directly upstream of the FIFO memory, supplying its `w_addr` and `w_full` inputs.

## Interface
- `ADDR_SIZE`, 4: memory address width; DEPTH = 2^ADDR_SIZE entries; pointers are ADDR_SIZE+1 bits.
- `AFULL_LEVEL`, 12: occupancy at or above which `w_almost_full` asserts; legal range 1..DEPTH.
- Clocking and reset (already decided): one clock, `w_clk`; reset `w_rst_n`, asynchronous and active-low.
- `w_clk` input, 1: write-domain clock; all state updates on its rising edge.
- `w_rst_n` input, 1: asynchronous active-low reset.
- `w_inc` input, 1: write request; data is written into memory this cycle when `w_inc && !w_full`.
- `r_ptr` input, ADDR_SIZE+1: Gray read pointer from the read domain; asynchronous to `w_clk`.
- `w_addr` output, ADDR_SIZE: binary write address, the low bits of the binary write pointer.
- `w_ptr` output, ADDR_SIZE+1: registered Gray write pointer, sent to the read domain.
- `w_full` output, 1: registered full flag.
- `w_count` output, ADDR_SIZE+1: registered conservative occupancy, range 0..DEPTH.
- `w_overflow` output, 1: one-cycle pulse, registered, when `w_inc && w_full`.
- `w_almost_full` output, 1: present only with `FIFO_AFULL_EN`.

## Operation
- State:
  - binary pointer `w_bin` (ADDR_SIZE+1 bits);
  - Gray pointer `w_ptr`;
  - two-flop synchronizer output `wq2_rptr`;
  - the registered flags.
- Write accept: when `w_inc && !w_full`, the next binary value is `w_bin + 1`, wrapping modulo 2^(ADDR_SIZE+1). Otherwise `w_bin` holds.
- Next Gray value: `g_next = (b_next >> 1) ^ b_next`.
- Full condition: `g_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}`. The result is registered into `w_full`.
- Count: `w_count` is registered from `b_next - gray2bin(wq2_rptr)`, modulo 2^(ADDR_SIZE+1).
- `w_count` never underestimates occupancy. A stale `wq2_rptr` can only overstate it.
- Writes while full are dropped: pointers hold and `w_overflow` pulses for 1 cycle.
- The `w_full` gate is internal. `w_inc` does not need to be qualified upstream.
- Reset values: all outputs are 0, including `w_full`, `w_count` and `w_overflow`, plus `w_almost_full` when present. The pointers and synchronizer flops are also 0.

## Timing
- `w_addr` and `w_ptr` advance at the same rising edge that accepts the write. The memory write uses the pre-edge `w_addr`.
- `w_full` asserts at the edge that accepts the DEPTH-th outstanding write. That is zero cycles of latency after the accepting edge, so the next `w_inc` is refused.
- Deassert latency: after `r_ptr` changes and is stable, the first edge captures it into sync stage 1. The second edge moves it to stage 2. The third edge updates `w_full`/`w_count`. So `w_full` deasserts on the 3rd rising edge.
- `r_ptr` changes by at most one Gray bit per read-clock edge. This is a guarantee from the read side; the block relies on it and does not check it.
- Wrap: after 2·DEPTH accepted writes, `w_bin` returns to 0 and the full comparison stays correct via the MSB.
- Simultaneous `w_inc` with a full release in the same cycle: `w_full` is the registered value and governs acceptance. The release takes effect on the following cycle.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock. Deassertion must be synchronous to `w_clk`, provided externally.

## Configuration
- `FIFO_AFULL_EN` defined:
  - `w_almost_full` port exists;
  - it is registered from `next_count >= AFULL_LEVEL`, on the same edge as `w_count`;
  - it has the same release latency as `w_full`;
  - reset value 0.
- Not defined: the `w_almost_full` port, its register and the `AFULL_LEVEL` check are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterized by width;
  - the pointer-width localparam convention `PTR_W = ADDR_SIZE+1`.
- One sub-module, `fifo_sync_2ff`: a 2-flop synchronizer with WIDTH parameter and asynchronous active-low reset, used for `r_ptr` to `wq2_rptr`. The read-side controller reuses it.

## Test plan
All scenarios use ADDR_SIZE=4 (DEPTH=16); `r_ptr` is driven from a behavioural read-domain model.
- Reset: assert `w_rst_n`=0 mid-burst -> all outputs are 0 immediately, with no clock edge needed.
- Fill: `r_ptr`=0, 16 consecutive `w_inc` -> `w_addr` steps 0..15, `w_count` reaches 16, `w_full`=1 at the 16th accepting edge, `w_ptr`=5'b11000.
- Overflow: while full, 3 more `w_inc` -> `w_addr` holds at 0, `w_overflow` pulses 3 times, `w_count` stays 16.
- Release: from full, drive `r_ptr`=5'b00001 (one read) -> `w_full` drops on the 3rd `w_clk` edge, `w_count`=15, and the next write is accepted.
- Wrap: 40 writes interleaved with matching reads -> `w_bin` wraps past 31, `w_ptr` is correct Gray, and there is no false `w_full`.
- With `FIFO_AFULL_EN`, `AFULL_LEVEL`=12: 12 writes, no reads -> `w_almost_full`=1 at the 12th edge and `w_full`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers: Gray/binary
// conversion and the pointer-width convention (pointers are one bit wider than addresses).
package fifo_pkg;

    localparam int DEFAULT_ADDR_SIZE = 4;

    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    // Both conversions operate on zero-extended values.
    // Any pointer width up to 32 bits is handled by casting at the call site.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // NOTE: sequential state uses non-blocking assignments so stage 2 samples the old stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag controller for the asynchronous FIFO.
// Define FIFO_AFULL_EN to add the registered w_almost_full output.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE   = DEFAULT_ADDR_SIZE
`ifdef FIFO_AFULL_EN
   ,parameter int AFULL_LEVEL = 12
`endif
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_inc,
    input  logic [ADDR_SIZE:0]   r_ptr,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic [ADDR_SIZE:0]   w_ptr,
    output logic                 w_full,
    output logic [ADDR_SIZE:0]   w_count,
    output logic                 w_overflow
`ifdef FIFO_AFULL_EN
   ,output logic                 w_almost_full
`endif
);

    localparam int PTR_W = ptr_width(ADDR_SIZE);
    localparam int MSB   = PTR_W - 1;

    logic [MSB:0] wq2_rptr;
    logic [MSB:0] w_bin_q,   w_bin_d;
    logic [MSB:0] w_ptr_q,   w_ptr_d;
    logic [MSB:0] w_count_q, w_count_d;
    logic         w_full_q,  w_full_d;
    logic         w_overflow_q;
    logic         accept;
    logic [MSB:0] rq_bin;

    fifo_sync_2ff #(.WIDTH(PTR_W)) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .d_i   (r_ptr),
        .q_o   (wq2_rptr)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        accept    = w_inc && !w_full_q;
        w_bin_d   = w_bin_q + PTR_W'(accept);
        w_ptr_d   = PTR_W'(bin2gray(32'(w_bin_d)));
        rq_bin    = PTR_W'(gray2bin(32'(wq2_rptr)));
        // Full when the write pointer is one lap ahead of the read pointer.
        // In Gray code that is the top two bits inverted, rest equal.
        w_full_d  = (w_ptr_d == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]});
        w_count_d = w_bin_d - rq_bin;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_bin_q      <= '0;
            w_ptr_q      <= '0;
            w_full_q     <= 1'b0;
            w_count_q    <= '0;
            w_overflow_q <= 1'b0;
        end else begin
            w_bin_q      <= w_bin_d;
            w_ptr_q      <= w_ptr_d;
            w_full_q     <= w_full_d;
            w_count_q    <= w_count_d;
            w_overflow_q <= w_inc && w_full_q;
        end
    end

`ifdef FIFO_AFULL_EN
    localparam logic [MSB:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

    logic w_afull_q;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_afull_q <= 1'b0;
        end else begin
            w_afull_q <= (w_count_d >= AFULL_THR);
        end
    end

    assign w_almost_full = w_afull_q;
`endif

    assign w_addr     = w_bin_q[ADDR_SIZE-1:0];
    assign w_ptr      = w_ptr_q;
    assign w_full     = w_full_q;
    assign w_count    = w_count_q;
    assign w_overflow = w_overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDR_SIZE=4, DEPTH=16).
// The read domain is modelled as a binary counter with a Gray-coded r_ptr.
module tb_fifo_wptr_full;

    logic       w_clk = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_inc = 1'b0;
    logic [4:0] r_ptr = '0;
    logic [3:0] w_addr;
    logic [4:0] w_ptr;
    logic       w_full;
    logic [4:0] w_count;
    logic       w_overflow;
`ifdef FIFO_AFULL_EN
    logic       w_almost_full;
`endif

    int checks = 0;
    int failures = 0;
    int wb = 0;
    int rb = 0;

    fifo_wptr_full #(
        .ADDR_SIZE (4)
`ifdef FIFO_AFULL_EN
       ,.AFULL_LEVEL (12)
`endif
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_inc      (w_inc),
        .r_ptr      (r_ptr),
        .w_addr     (w_addr),
        .w_ptr      (w_ptr),
        .w_full     (w_full),
        .w_count    (w_count),
        .w_overflow (w_overflow)
`ifdef FIFO_AFULL_EN
       ,.w_almost_full (w_almost_full)
`endif
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(w_addr), 0);
        check({tag, "_ptr"},   32'(w_ptr), 0);
        check({tag, "_full"},  32'(w_full), 0);
        check({tag, "_count"}, 32'(w_count), 0);
        check({tag, "_ovf"},   32'(w_overflow), 0);
`ifdef FIFO_AFULL_EN
        check({tag, "_afull"}, 32'(w_almost_full), 0);
`endif
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge w_clk);
        w_rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Fill: 16 accepted writes against an empty read side.
        w_inc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fill_addr", 32'(w_addr), 32'(i));
            tick();
            check("fill_count", 32'(w_count), 32'(i + 1));
            check("fill_full", 32'(w_full), (i == 15) ? 32'd1 : 32'd0);
        end
        check("fill_ptr", 32'(w_ptr), 32'b11000);
        check("fill_addr_wrap", 32'(w_addr), 0);

        // Overflow: writes while full are dropped and flagged.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_pulse", 32'(w_overflow), 1);
            check("ovf_addr", 32'(w_addr), 0);
            check("ovf_count", 32'(w_count), 16);
            check("ovf_ptr", 32'(w_ptr), 32'b11000);
        end
        w_inc = 1'b0;
        tick();
        check("ovf_clear", 32'(w_overflow), 0);

        // Release: one read, w_full drops on the third edge.
        r_ptr = 5'b00001;
        tick();
        check("rel_full_e1", 32'(w_full), 1);
        tick();
        check("rel_full_e2", 32'(w_full), 1);
        tick();
        check("rel_full_e3", 32'(w_full), 0);
        check("rel_count", 32'(w_count), 15);
        w_inc = 1'b1;
        tick();
        w_inc = 1'b0;
        check("rel_wr_addr", 32'(w_addr), 1);
        check("rel_wr_ptr", 32'(w_ptr), 32'b11001);
        check("rel_wr_full", 32'(w_full), 1);
        check("rel_wr_count", 32'(w_count), 16);

        // Asynchronous reset asserted mid-burst, away from any clock edge.
        w_inc = 1'b1;
        tick();
        tick();
        #2;
        w_rst_n = 1'b0;
        r_ptr = '0;
        #1;
        check_all_zero("async_rst");
        w_inc = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;

        // Wrap: 40 writes interleaved with matching reads, occupancy never above 1.
        wb = 0;
        rb = 0;
        for (int k = 0; k < 40; k++) begin
            w_inc = 1'b1;
            tick();
            w_inc = 1'b0;
            wb = (wb + 1) % 32;
            check("wrap_ptr", 32'(w_ptr), 32'(gray5(wb)));
            check("wrap_addr", 32'(w_addr), 32'(wb % 16));
            check("wrap_full", 32'(w_full), 0);
            check("wrap_count1", 32'(w_count), 1);
            rb = (rb + 1) % 32;
            r_ptr = gray5(rb);
            tick();
            tick();
            tick();
            check("wrap_count0", 32'(w_count), 0);
        end
        check("wrap_final_ptr", 32'(w_ptr), 32'b01100);

`ifdef FIFO_AFULL_EN
        // Almost-full: 12 writes with no reads.
        #2;
        w_rst_n = 1'b0;
        r_ptr = '0;
        #1;
        @(negedge w_clk);
        w_rst_n = 1'b1;
        w_inc = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("afull_flag", 32'(w_almost_full), (i == 11) ? 32'd1 : 32'd0);
            check("afull_full", 32'(w_full), 0);
        end
        w_inc = 1'b0;
        check("afull_count", 32'(w_count), 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
